vecmat_add_tree: RTL and testbench

- Parametrised, pipelined fixed-point reduction tree. Sums NUM_IN lanes of DW-bit two's-complement data into one DW-bit result.
- Generalises the fixed 32-lane vecmat adders: configurable lane count and pipeline-register spacing, plus valid tracking.
- Adds a multi-beat accumulator, so vectors longer than NUM_IN reduce over several beats.
- Sits between the vector-multiply array and the attention score/output buffers.

---
 rtl/vecmat_add_tree_pkg.sv | 63 ++++++
 rtl/vecmat_add_tree_level.sv | 85 ++++++++
 rtl/vecmat_add_tree.sv | 130 +++++++++++++
 tb/tb_vecmat_add_tree.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vecmat_add_tree_pkg.sv
// ---------------------------------------------------------------------------
// vecmat_pkg : shared helpers for the vecmat adder tree.
//   clog2     - ceiling log2 for elaboration-time sizing
//   tree_lat  - number of register stages in the tree
//   sat_add   - DW-generic signed add with overflow flag. Operands must be
//               sign-extended to MAXW bits; the caller keeps the low DW bits.
//   LEVELS / TREE_LAT - values for the default 32-lane, PIPE_EVERY=1 build.
// Optional feature macro: VECADD_SATURATE_EN (saturate instead of wrap).
// ---------------------------------------------------------------------------
package vecmat_pkg;

   localparam int unsigned MAXW = 64;

   typedef struct packed {
      logic            ovf;
      logic [MAXW-1:0] val;
   } add_res_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      longint unsigned x;
      r = 0;
      x = 1;
      while (x < longint'(v)) begin
         x = x << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned tree_lat(input int unsigned levels,
                                            input int unsigned pipe_every);
      return (levels + pipe_every - 1) / pipe_every;
   endfunction

   localparam int unsigned LEVELS   = clog2(32);
   localparam int unsigned TREE_LAT = tree_lat(LEVELS, 1);

   // Operands are exact (sign-extended), so the MAXW-bit sum never wraps;
   // leaving the DW-bit range is then exactly "equal signs, different result".
   function automatic add_res_t sat_add(input logic signed [MAXW-1:0] a,
                                        input logic signed [MAXW-1:0] b,
                                        input int unsigned             dw);
      logic signed [MAXW-1:0] s;
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      add_res_t               r;
      s     = a + b;
      hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.ovf = (s > hi) || (s < lo);
      r.val = s;
`ifdef VECADD_SATURATE_EN
      if (s > hi) begin
         r.val = hi;
      end else if (s < lo) begin
         r.val = lo;
      end
`endif
      return r;
   endfunction

endpackage

// File: rtl/vecmat_add_tree_level.sv
// ---------------------------------------------------------------------------
// vecmat_add_level : one level of the reduction tree.
// Adds adjacent lane pairs (IN_LANES -> IN_LANES/2) and ORs any adder
// overflow into the beat's ovf bit. With REG=1 data and sideband
// (valid/first/last/ovf) are registered; with REG=0 the level is combinational.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   i_valid/i_first/i_last/i_ovf  sideband in
//   i_data  [IN_LANES*DW]         lanes in
//   o_valid/o_first/o_last/o_ovf  sideband out
//   o_data  [IN_LANES/2*DW]       pairwise sums out
// Optional feature macro: VECADD_SATURATE_EN (via vecmat_pkg::sat_add).
// ---------------------------------------------------------------------------
module vecmat_add_level
   import vecmat_pkg::*;
#(
   parameter int unsigned DW       = 16,
   parameter int unsigned IN_LANES = 2,
   parameter bit          REG      = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_valid,
   input  logic                         i_first,
   input  logic                         i_last,
   input  logic                         i_ovf,
   input  logic [IN_LANES*DW-1:0]       i_data,
   output logic                         o_valid,
   output logic                         o_first,
   output logic                         o_last,
   output logic                         o_ovf,
   output logic [(IN_LANES/2)*DW-1:0]   o_data
);

   localparam int unsigned OUT_LANES = IN_LANES / 2;

   logic [OUT_LANES*DW-1:0] w_sum;
   logic                    w_ovf;
   logic [DW-1:0]           w_a;
   logic [DW-1:0]           w_b;
   add_res_t                w_res;

   always_comb begin
      w_sum = '0;
      w_ovf = i_ovf;
      w_a   = '0;
      w_b   = '0;
      w_res = '0;
      for (int unsigned k = 0; k < OUT_LANES; k++) begin
         w_a   = i_data[(2*k)*DW +: DW];
         w_b   = i_data[(2*k+1)*DW +: DW];
         w_res = sat_add({{(MAXW-DW){w_a[DW-1]}}, w_a},
                         {{(MAXW-DW){w_b[DW-1]}}, w_b}, DW);
         w_sum[k*DW +: DW] = w_res.val[DW-1:0];
         w_ovf = w_ovf | w_res.ovf;
      end
   end

   generate
      if (REG) begin : g_reg
         always_ff @(posedge clk) begin
            if (!reset) begin
               o_valid <= 1'b0;
               o_first <= 1'b0;
               o_last  <= 1'b0;
               o_ovf   <= 1'b0;
               o_data  <= '0;
            end else begin
               o_valid <= i_valid;
               o_first <= i_first;
               o_last  <= i_last;
               o_ovf   <= w_ovf;
               o_data  <= w_sum;
            end
         end
      end else begin : g_comb
         assign o_valid = i_valid;
         assign o_first = i_first;
         assign o_last  = i_last;
         assign o_ovf   = w_ovf;
         assign o_data  = w_sum;
      end
   endgenerate

endmodule

// File: rtl/vecmat_add_tree.sv
// ---------------------------------------------------------------------------
// vecmat_add_tree : pipelined NUM_IN-lane signed reduction tree with a
// multi-beat accumulator and overflow tracking.
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   in_valid   beat present
//   in_first   beat starts a new accumulation
//   in_last    beat ends the accumulation
//   in_data    NUM_IN*DW lanes, lane k = in_data[k*DW +: DW]
//   out_valid  one-cycle result pulse
//   out_data   accumulated result, held between pulses
//   out_ovf    overflow/saturation seen anywhere in this result
// Latency from an in_last beat to out_valid: ceil(LEVELS/PIPE_EVERY)+1.
// Optional feature macro: VECADD_SATURATE_EN (saturate instead of wrap).
// ---------------------------------------------------------------------------
module vecmat_add_tree
   import vecmat_pkg::*;
#(
   parameter int unsigned DW         = 16,
   parameter int unsigned NUM_IN     = 32,
   parameter int unsigned PIPE_EVERY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [NUM_IN*DW-1:0] in_data,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic                 out_ovf
);

   localparam int unsigned L_LEVELS = clog2(NUM_IN);

   // Level j uses only the low (NUM_IN>>j)*DW bits of w_data[j].
   logic [NUM_IN*DW-1:0] w_data [0:L_LEVELS];
   logic [L_LEVELS:0]    w_valid;
   logic [L_LEVELS:0]    w_first;
   logic [L_LEVELS:0]    w_last;
   logic [L_LEVELS:0]    w_ovf;

   assign w_data[0]  = in_data;
   assign w_valid[0] = in_valid;
   assign w_first[0] = in_first;
   assign w_last[0]  = in_last;
   assign w_ovf[0]   = 1'b0;

   generate
      for (genvar j = 1; j <= L_LEVELS; j++) begin : g_lvl
         localparam int unsigned IN_L = NUM_IN >> (j - 1);
         localparam bit          LREG = ((j % PIPE_EVERY) == 0) || (j == L_LEVELS);

         vecmat_add_level #(
            .DW       (DW),
            .IN_LANES (IN_L),
            .REG      (LREG)
         ) u_lvl (
            .clk     (clk),
            .reset   (reset),
            .i_valid (w_valid[j-1]),
            .i_first (w_first[j-1]),
            .i_last  (w_last[j-1]),
            .i_ovf   (w_ovf[j-1]),
            .i_data  (w_data[j-1][IN_L*DW-1:0]),
            .o_valid (w_valid[j]),
            .o_first (w_first[j]),
            .o_last  (w_last[j]),
            .o_ovf   (w_ovf[j]),
            .o_data  (w_data[j][(IN_L/2)*DW-1:0])
         );

         assign w_data[j][NUM_IN*DW-1:(IN_L/2)*DW] = '0;
      end
   endgenerate

   logic [DW-1:0] r_acc;
   logic          r_acc_ovf;
   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic          r_out_ovf;

   logic [DW-1:0] w_sum;
   logic [DW-1:0] w_base;
   logic          w_base_ovf;
   add_res_t      w_res;
   logic [DW-1:0] w_new;
   logic          w_new_ovf;

   // A first beat restarts from zero, silently dropping any partial result.
   always_comb begin
      w_sum      = w_data[L_LEVELS][DW-1:0];
      w_base     = w_first[L_LEVELS] ? '0 : r_acc;
      w_base_ovf = w_first[L_LEVELS] ? 1'b0 : r_acc_ovf;
      w_res      = sat_add({{(MAXW-DW){w_base[DW-1]}}, w_base},
                           {{(MAXW-DW){w_sum[DW-1]}}, w_sum}, DW);
      w_new      = w_res.val[DW-1:0];
      w_new_ovf  = w_res.ovf | w_ovf[L_LEVELS] | w_base_ovf;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc       <= '0;
         r_acc_ovf   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_valid[L_LEVELS]) begin
            if (w_last[L_LEVELS]) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_new;
               r_out_ovf   <= w_new_ovf;
               r_acc       <= '0;
               r_acc_ovf   <= 1'b0;
            end else begin
               r_acc       <= w_new;
               r_acc_ovf   <= w_new_ovf;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_vecmat_add_tree.sv
// ---------------------------------------------------------------------------
// tb_vecmat_add_tree : directed self-checking bench for vecmat_add_tree.
// Two instances: 32 lanes / PIPE_EVERY=1 and 8 lanes / PIPE_EVERY=2.
// Expected results follow VECADD_SATURATE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_vecmat_add_tree;

   localparam int unsigned DW = 16;
   localparam int unsigned N  = 32;
   localparam int unsigned N8 = 8;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic        ovf;
   } pulse_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_first, in_last;
   logic [N*DW-1:0] in_data;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_ovf;

   logic             in_valid8;
   logic [N8*DW-1:0] in_data8;
   logic             out_valid8;
   logic [DW-1:0]    out_data8;
   logic             out_ovf8;

   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;
   pulse_t q[$];
   pulse_t q8[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vecmat_add_tree #(.DW(DW), .NUM_IN(N), .PIPE_EVERY(1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .in_data(in_data), .out_valid(out_valid),
      .out_data(out_data), .out_ovf(out_ovf));

   vecmat_add_tree #(.DW(DW), .NUM_IN(N8), .PIPE_EVERY(2)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_first(1'b1),
      .in_last(1'b1), .in_data(in_data8), .out_valid(out_valid8),
      .out_data(out_data8), .out_ovf(out_ovf8));

   always @(negedge clk) begin
      if (out_valid)  q.push_back('{cyc, out_data, out_ovf});
      if (out_valid8) q8.push_back('{cyc, out_data8, out_ovf8});
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
      logic [N*DW-1:0] d;
      for (int k = 0; k < N; k++) d[k*DW +: DW] = v;
      return d;
   endfunction

   task automatic beat(input logic f, input logic l, input logic [DW-1:0] v,
                       output int t);
      @(negedge clk);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      in_data  = fill(v);
      t = cyc;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   // Checks exactly one pulse with the given latency/data/ovf, then clears.
   task automatic expect_one(input string tag, input int t0, input int lat,
                             input logic [15:0] d, input logic o);
      check({tag, "_count"}, q.size(), 1);
      if (q.size() > 0) begin
         check({tag, "_lat"},  q[0].cyc - t0, lat);
         check({tag, "_data"}, q[0].data, d);
         check({tag, "_ovf"},  q[0].ovf, o);
      end
      q.delete();
   endtask

   initial begin
      int t, t0;
      logic [15:0] ovf_exp;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      in_valid8 = 1'b0;
      in_data8  = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data, 0);
      check("rst_ovf",   out_ovf, 0);
      reset = 1'b1;
      idle(2);
      q.delete();

      // Single beat, lanes 1 -> 32
      beat(1, 1, 16'h0001, t);
      idle(10);
      expect_one("single", t, 6, 16'h0020, 1'b0);

      // Completed vector cleared the accumulator: no-first beat starts at 0
      beat(0, 1, 16'h0002, t);
      idle(10);
      expect_one("nofirst", t, 6, 16'h0040, 1'b0);

      // Three-beat vector: 32*(2+3+4) = 288
      beat(1, 0, 16'h0002, t);
      beat(0, 0, 16'h0003, t);
      beat(0, 1, 16'h0004, t);
      idle(10);
      expect_one("multi", t, 6, 16'h0120, 1'b0);

      // Overflow in tree level 4 (0x4000+0x4000)
`ifdef VECADD_SATURATE_EN
      ovf_exp = 16'h7FFF;
`else
      ovf_exp = 16'h0000;
`endif
      beat(1, 1, 16'h0800, t);
      idle(10);
      expect_one("ovf", t, 6, ovf_exp, 1'b1);

      // All lanes -1 -> -32, no overflow
      beat(1, 1, 16'hFFFF, t);
      idle(10);
      expect_one("neg", t, 6, 16'hFFE0, 1'b0);

      // Streaming: 10 back-to-back single-beat vectors
      for (int i = 0; i < 10; i++) begin
         beat(1, 1, 16'(i), t);
         if (i == 0) t0 = t;
      end
      idle(12);
      check("stream_count", q.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < q.size()) begin
            check($sformatf("stream_data%0d", i), q[i].data, 32 * i);
            check($sformatf("stream_cyc%0d", i), q[i].cyc - t0, 6 + i);
         end
      end
      q.delete();

      // Reset mid-operation: partial accumulation + 3 beats in flight
      beat(1, 0, 16'h0007, t);
      idle(8);
      beat(1, 1, 16'h0005, t);
      beat(0, 0, 16'h0005, t);
      beat(0, 1, 16'h0005, t);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      reset    = 1'b1;
      check("rstmid_data", out_data, 0);
      check("rstmid_ovf",  out_ovf, 0);
      idle(10);
      check("rstmid_nopulse", q.size(), 0);
      q.delete();
      beat(0, 1, 16'h0001, t);
      idle(10);
      expect_one("postrst", t, 6, 16'h0020, 1'b0);

      // 8 lanes, PIPE_EVERY=2, lanes 1..8 -> 36, latency 3
      @(negedge clk);
      q8.delete();
      in_valid8 = 1'b1;
      for (int k = 0; k < N8; k++) in_data8[k*DW +: DW] = 16'(k + 1);
      t = cyc;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (6) @(negedge clk);
      check("n8_count", q8.size(), 1);
      if (q8.size() > 0) begin
         check("n8_lat",  q8[0].cyc - t, 3);
         check("n8_data", q8[0].data, 16'h0024);
         check("n8_ovf",  q8[0].ovf, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
